// File: rtl/bky_load_shifter_if.sv
// Strobe/data bundle between the load controller and bky_load_shifter.
interface bky_load_shifter_if;
  logic        CLR_CNT;
  logic        RDENA;
  logic        SHFT_ENA;
  logic        SET_DONE;
  logic [15:0] FIFO_DOUT;
  logic [3:0]  CNT;
  logic [4:0]  LOOP;
  logic        SDATA;
  logic [15:0] CHKSUM;
  logic        LOAD_DONE;
  logic        OVFL;

  modport master (
    output CLR_CNT, RDENA, SHFT_ENA, SET_DONE, FIFO_DOUT,
    input  CNT, LOOP, SDATA, CHKSUM, LOAD_DONE, OVFL
  );

  modport slave (
    input  CLR_CNT, RDENA, SHFT_ENA, SET_DONE, FIFO_DOUT,
    output CNT, LOOP, SDATA, CHKSUM, LOAD_DONE, OVFL
  );
endinterface

// File: rtl/bky_load_shifter.sv
// Loads FIFO words and shifts them out MSB first, tracking word index, bit count and XOR checksum.
// One-cycle strobe-to-output latency; define BKY_SHFT_TMR_EN for triplicated, majority-voted state.
module bky_load_shifter (
  input  logic              CLK,
  input  logic              RST,
  bky_load_shifter_if.slave bus
);

  typedef struct packed {
    logic [15:0] word;
    logic [3:0]  cnt;
    logic [4:0]  loop;
    logic [15:0] chksum;
    logic        sdata;
    logic        done;
    logic        ovfl;
    logic        first;
  } st_t;

  localparam st_t ST_RST = '{word: 16'h0000, cnt: 4'h0, loop: 5'h00, chksum: 16'h0000,
                             sdata: 1'b0, done: 1'b0, ovfl: 1'b0, first: 1'b1};

  st_t w_cur;
  st_t w_nxt;

  always_comb begin
    w_nxt = w_cur;
    if (bus.CLR_CNT) begin
      w_nxt = ST_RST;
    end else begin
      if (bus.RDENA) begin
        w_nxt.word = bus.FIFO_DOUT;
        w_nxt.cnt  = 4'h0;
        if (!w_cur.done) w_nxt.chksum = w_cur.chksum ^ bus.FIFO_DOUT;
        if (w_cur.first) begin
          w_nxt.first = 1'b0;
        end else if (w_cur.loop == 5'd31) begin
          w_nxt.ovfl = 1'b1;
        end else begin
          w_nxt.loop = w_cur.loop + 5'd1;
        end
      end else if (bus.SHFT_ENA) begin
        w_nxt.sdata = w_cur.word[15];
        w_nxt.word  = {w_cur.word[14:0], 1'b0};
        if (w_cur.cnt != 4'hF) w_nxt.cnt = w_cur.cnt + 4'h1;
      end
      if (bus.SET_DONE) w_nxt.done = 1'b1;
    end
  end

`ifdef BKY_SHFT_TMR_EN
  // Each copy reloads from the voted value, so a single upset copy heals on the next edge.
  (* keep = "true" *) st_t r_st_a;
  (* keep = "true" *) st_t r_st_b;
  (* keep = "true" *) st_t r_st_c;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_st_a <= ST_RST;
    else     r_st_a <= w_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_st_b <= ST_RST;
    else     r_st_b <= w_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_st_c <= ST_RST;
    else     r_st_c <= w_nxt;
  end

  assign w_cur = st_t'((r_st_a & r_st_b) | (r_st_a & r_st_c) | (r_st_b & r_st_c));
`else
  st_t r_st;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_st <= ST_RST;
    else     r_st <= w_nxt;
  end

  assign w_cur = r_st;
`endif

  assign bus.CNT       = w_cur.cnt;
  assign bus.LOOP      = w_cur.loop;
  assign bus.SDATA     = w_cur.sdata;
  assign bus.CHKSUM    = w_cur.chksum;
  assign bus.LOAD_DONE = w_cur.done;
  assign bus.OVFL      = w_cur.ovfl;

endmodule

// File: tb/tb_bky_load_shifter.sv
// Directed and randomized checks of bky_load_shifter against an operation-level reference model.
module tb_bky_load_shifter;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  bky_load_shifter_if bus ();

  bky_load_shifter dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: word as an integer, LOOP/OVFL derived from count of words loaded.
  int m_word, m_cnt, m_nload, m_chk, m_sdata, m_done;

  task automatic model_reset();
    m_word = 0; m_cnt = 0; m_nload = 0; m_chk = 0; m_sdata = 0; m_done = 0;
  endtask

  function automatic int exp_loop();
    if (m_nload == 0) return 0;
    return (m_nload - 1 > 31) ? 31 : m_nload - 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".CNT"},       32'(bus.CNT),       32'(m_cnt));
    check({tag, ".LOOP"},      32'(bus.LOOP),      32'(exp_loop()));
    check({tag, ".SDATA"},     32'(bus.SDATA),     32'(m_sdata));
    check({tag, ".CHKSUM"},    32'(bus.CHKSUM),    32'(m_chk));
    check({tag, ".LOAD_DONE"}, 32'(bus.LOAD_DONE), 32'(m_done));
    check({tag, ".OVFL"},      32'(bus.OVFL),      32'(m_nload > 32));
  endtask

  task automatic step(input bit clr, input bit rd, input bit sh, input bit sd, input logic [15:0] din);
    bus.CLR_CNT = clr; bus.RDENA = rd; bus.SHFT_ENA = sh; bus.SET_DONE = sd; bus.FIFO_DOUT = din;
    @(posedge CLK);
    #1;
    bus.CLR_CNT = 1'b0; bus.RDENA = 1'b0; bus.SHFT_ENA = 1'b0; bus.SET_DONE = 1'b0;
    if (clr) begin
      model_reset();
    end else begin
      if (rd) begin
        m_word = int'(din);
        m_cnt  = 0;
        if (m_done == 0) m_chk = m_chk ^ int'(din);
        m_nload++;
      end else if (sh) begin
        m_sdata = (m_word >> 15) & 1;
        m_word  = (m_word * 2) % 65536;
        if (m_cnt < 15) m_cnt++;
      end
      if (sd) m_done = 1;
    end
  endtask

  initial begin
    logic [15:0] pat;
    int          xr;
    bus.CLR_CNT = 1'b0; bus.RDENA = 1'b0; bus.SHFT_ENA = 1'b0; bus.SET_DONE = 1'b0;
    bus.FIFO_DOUT = 16'h0000;
    model_reset();

    // Reset state
    #2;
    check_all("reset");
    @(negedge CLK);
    RST = 1'b0;

    // Single word A5C3 shifted out fully, CNT saturating
    pat = 16'hA5C3;
    step(1, 0, 0, 0, 16'h0);
    step(0, 1, 0, 0, pat);
    check_all("a5c3_load");
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 0, 16'h0);
      check("a5c3_sdata", 32'(bus.SDATA), 32'(pat[15 - i]));
      check("a5c3_cnt",   32'(bus.CNT),   (i < 15) ? 32'(i + 1) : 32'd15);
      check_all("a5c3_shift");
    end
    check("a5c3_chk", 32'(bus.CHKSUM), 32'h0000A5C3);

    // 19 words 1..19, then SET_DONE; checksum is XOR of 1..19
    step(1, 0, 0, 0, 16'h0);
    xr = 0;
    for (int k = 1; k <= 19; k++) begin
      step(0, 1, 0, 0, 16'(k));
      xr ^= k;
      for (int s = 0; s < 16; s++) step(0, 0, 1, 0, 16'h0);
      check_all("seq19");
    end
    step(0, 0, 0, 1, 16'h0);
    check("seq19_loop", 32'(bus.LOOP), 32'd18);
    check("seq19_chk",  32'(bus.CHKSUM), 32'(xr));
    check("seq19_done", 32'(bus.LOAD_DONE), 32'd1);
    check("seq19_ovfl", 32'(bus.OVFL), 32'd0);
    step(0, 1, 0, 0, 16'hBEEF);
    check("frozen_chk",  32'(bus.CHKSUM), 32'(xr));
    check("frozen_loop", 32'(bus.LOOP), 32'd19);

    // 33 loads: LOOP saturates at 31, OVFL on the 33rd
    step(1, 0, 0, 0, 16'h0);
    for (int k = 1; k <= 33; k++) begin
      step(0, 1, 0, 0, 16'($urandom));
      check("ovf_loop", 32'(bus.LOOP), (k > 32) ? 32'd31 : 32'(k - 1));
      check("ovf_flag", 32'(bus.OVFL), (k == 33) ? 32'd1 : 32'd0);
      check_all("ovf");
    end

    // Load beats shift in the same cycle
    step(1, 0, 0, 0, 16'h0);
    step(0, 1, 0, 0, 16'h8000);
    step(0, 0, 1, 0, 16'h0);
    check("pre_both_sdata", 32'(bus.SDATA), 32'd1);
    step(0, 1, 1, 0, 16'hFFFF);
    check("both_cnt",   32'(bus.CNT), 32'd0);
    check("both_sdata", 32'(bus.SDATA), 32'd1);
    check_all("both");

    // Async reset mid-word
    step(1, 0, 0, 0, 16'h0);
    step(0, 1, 0, 0, 16'h1234);
    step(0, 1, 0, 0, 16'h5A5A);
    for (int s = 0; s < 7; s++) step(0, 0, 1, 0, 16'h0);
    RST = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge CLK);
    RST = 1'b0;
    step(0, 1, 0, 0, 16'h00FF);
    check("post_rst_loop", 32'(bus.LOOP), 32'd0);
    step(0, 0, 1, 0, 16'h0);
    check_all("post_rst_shift");

`ifdef BKY_SHFT_TMR_EN
    // Upset one copy of CNT; voted output and shifting must be unaffected
    step(1, 0, 0, 0, 16'h0);
    step(0, 1, 0, 0, 16'hA5C3);
    for (int s = 0; s < 3; s++) step(0, 0, 1, 0, 16'h0);
    force dut.r_st_b.cnt = 4'hA;
    #1;
    check("tmr_cnt_vote", 32'(bus.CNT), 32'd3);
    release dut.r_st_b.cnt;
    for (int s = 0; s < 4; s++) begin
      step(0, 0, 1, 0, 16'h0);
      check_all("tmr_shift");
    end
    check("tmr_copy_heal", 32'(dut.r_st_b.cnt), 32'(m_cnt));
`endif

    // Randomized strobes
    step(1, 0, 0, 0, 16'h0);
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 40) == 0, 16'($urandom));
      check_all("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
